// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: state encoding, counter width
// default and the mapping from legacy hold/flush stage controls.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  localparam int unsigned STALL_CW_DEFAULT = 16;

  // Legacy stage control as driven by the old hold/flush stage registers.
  typedef enum logic [1:0] {
    HF_RUN   = 2'd0,
    HF_WAIT  = 2'd1,
    HF_FLUSH = 2'd2
  } hold_ctrl_e;

  // hold_flush becomes flush_i at a stage wrapper.
  function automatic logic hold_to_flush(hold_ctrl_e ctrl);
    return ctrl == HF_FLUSH;
  endfunction

  // hold_wait becomes out_ready=0 at a stage wrapper.
  function automatic logic hold_to_out_ready(hold_ctrl_e ctrl);
    return ctrl != HF_WAIT;
  endfunction

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module pipe_stall_counter #(
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer (main M, skid S), registered
// in_ready, flush to DEFAULT and a saturating back-pressure counter.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned    DW         = 32,
  parameter logic [DW-1:0]  DEFAULT    = {DW{1'b0}},
  parameter int unsigned    CW         = STALL_CW_DEFAULT,
  parameter bit             PASS_EMPTY = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [1:0]    occupancy_o,
  output logic [CW-1:0] stall_cnt_o,
  input  logic          stall_clr_i
);

  skid_state_e   state_q, state_d;
  logic [DW-1:0] m_q, m_d;
  logic [DW-1:0] s_q, s_d;
  logic          in_ready_q, in_ready_d;
  logic          in_xfer, out_xfer;

  assign out_valid = (state_q == ST_ONE) || (state_q == ST_TWO);
  assign in_xfer   = in_valid && in_ready_q;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      m_d     = DEFAULT;
      s_d     = DEFAULT;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            m_d     = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            m_d = in_data;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end else if (in_xfer) begin
            s_d     = in_data;
            state_d = ST_TWO;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            m_d     = s_q;
            state_d = ST_ONE;
          end
        end
        // occ=3 is unreachable in normal operation; fall back to empty.
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      m_q        <= DEFAULT;
      s_q        <= DEFAULT;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign occupancy_o = state_q;
  assign out_data    = (PASS_EMPTY && !out_valid) ? DEFAULT : m_q;

  pipe_stall_counter #(
    .CW (CW)
  ) u_stall_counter (
    .clk   (clk),
    .rst   (rst),
    .inc_i (out_valid && !out_ready),
    .clr_i (stall_clr_i),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: two instances share stimulus and differ only in PASS_EMPTY.
module tb_pipe_stage_skid;

  localparam logic [7:0] DEF = 8'hEE;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush_i;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       stall_clr_i;

  logic       in_ready0, out_valid0, in_ready1, out_valid1;
  logic [7:0] out_data0, out_data1;
  logic [1:0] occ0, occ1;
  logic [1:0] stall0, stall1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DW         (8),
    .DEFAULT    (DEF),
    .CW         (2),
    .PASS_EMPTY (1'b0)
  ) dut0 (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready0),
    .out_valid   (out_valid0),
    .out_data    (out_data0),
    .out_ready   (out_ready),
    .occupancy_o (occ0),
    .stall_cnt_o (stall0),
    .stall_clr_i (stall_clr_i)
  );

  pipe_stage_skid #(
    .DW         (8),
    .DEFAULT    (DEF),
    .CW         (2),
    .PASS_EMPTY (1'b1)
  ) dut1 (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready1),
    .out_valid   (out_valid1),
    .out_data    (out_data1),
    .out_ready   (out_ready),
    .occupancy_o (occ1),
    .stall_cnt_o (stall1),
    .stall_clr_i (stall_clr_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] stream [4];
    logic [1:0] stall_exp [6];
    stream    = '{8'h01, 8'h02, 8'h03, 8'h04};
    stall_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    rst = 1'b1; flush_i = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    out_ready = 1'b0; stall_clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_in_ready", 32'(in_ready0), 32'd1);
    chk("rst_out_data0", 32'(out_data0), 32'(DEF));
    chk("rst_out_data1", 32'(out_data1), 32'(DEF));
    chk("rst_occ", 32'(occ0), 32'd0);
    chk("rst_stall", 32'(stall0), 32'd0);

    // Streaming 1..4 with out_ready=1
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = stream[i];
      step();
      chk("stream_valid", 32'(out_valid0), 32'd1);
      chk("stream_data", 32'(out_data0), 32'(stream[i]));
      chk("stream_in_ready", 32'(in_ready0), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_valid", 32'(out_valid0), 32'd0);
    chk("stream_drain_occ", 32'(occ0), 32'd0);
    chk("stream_stall", 32'(stall0), 32'd0);

    // Back-pressure: A, then B into skid, C refused for several stalled cycles
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h0A;
    step();
    chk("bp_occ1", 32'(occ0), 32'd1);
    chk("bp_data_a", 32'(out_data0), 32'h0A);
    chk("bp_in_ready1", 32'(in_ready0), 32'd1);
    chk("bp_stall0", 32'(stall0), 32'd0);
    in_data = 8'h0B;
    for (int i = 0; i < 6; i++) begin
      step();
      in_data = 8'h0C;
      chk("bp_occ2", 32'(occ0), 32'd2);
      chk("bp_in_ready0", 32'(in_ready0), 32'd0);
      chk("bp_hold_a", 32'(out_data0), 32'h0A);
      chk("stall_sat", 32'(stall0), 32'(stall_exp[i]));
    end
    in_valid    = 1'b0;
    stall_clr_i = 1'b1;
    step();
    stall_clr_i = 1'b0;
    chk("stall_clr", 32'(stall0), 32'd0);
    chk("bp_still_a", 32'(out_data0), 32'h0A);
    out_ready = 1'b1;
    step();
    chk("rel_data_b", 32'(out_data0), 32'h0B);
    chk("rel_occ1", 32'(occ0), 32'd1);
    chk("rel_in_ready", 32'(in_ready0), 32'd1);
    step();
    chk("rel_empty", 32'(out_valid0), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h0C;
    step();
    chk("rel_data_c", 32'(out_data0), 32'h0C);
    chk("rel_valid_c", 32'(out_valid0), 32'd1);
    in_valid = 1'b0;
    step();
    chk("rel_drained", 32'(occ0), 32'd0);
    chk("rel_stall", 32'(stall0), 32'd0);

    // Flush with occupancy 2 and handshakes offered on the same edge
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    step();
    in_data = 8'h22;
    step();
    chk("fl_pre_occ", 32'(occ0), 32'd2);
    flush_i   = 1'b1;
    out_ready = 1'b1;
    in_data   = 8'h33;
    step();
    flush_i = 1'b0;
    chk("fl_valid", 32'(out_valid0), 32'd0);
    chk("fl_occ", 32'(occ0), 32'd0);
    chk("fl_in_ready", 32'(in_ready0), 32'd1);
    chk("fl_data", 32'(out_data0), 32'(DEF));
    chk("fl_stall_kept", 32'(stall0), 32'd1);
    in_valid = 1'b0;
    step();
    chk("fl_no_beat", 32'(out_valid0), 32'd0);

    // Flush from ONE kills the simultaneous in and out transfers
    in_valid = 1'b1;
    in_data  = 8'h44;
    step();
    flush_i = 1'b1;
    in_data = 8'h66;
    step();
    flush_i  = 1'b0;
    in_valid = 1'b0;
    chk("fl1_occ", 32'(occ0), 32'd0);
    chk("fl1_data", 32'(out_data0), 32'(DEF));
    step();
    chk("fl1_no_beat", 32'(out_valid0), 32'd0);

    // Asynchronous reset mid-cycle with occupancy 2
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    step();
    in_data = 8'h88;
    step();
    in_valid = 1'b0;
    chk("ar_pre_occ", 32'(occ0), 32'd2);
    chk("ar_pre_stall", 32'(stall0), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid0), 32'd0);
    chk("ar_in_ready", 32'(in_ready0), 32'd1);
    chk("ar_data", 32'(out_data0), 32'(DEF));
    chk("ar_occ", 32'(occ0), 32'd0);
    chk("ar_stall", 32'(stall0), 32'd0);
    chk("ar_valid1", 32'(out_valid1), 32'd0);
    #1 rst = 1'b0;

    // PASS_EMPTY 0 holds last beat, 1 shows DEFAULT
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    step();
    chk("pe_valid", 32'(out_valid1), 32'd1);
    chk("pe_data1_full", 32'(out_data1), 32'h55);
    in_valid = 1'b0;
    step();
    chk("pe_empty", 32'(out_valid0), 32'd0);
    chk("pe0_hold", 32'(out_data0), 32'h55);
    chk("pe1_default", 32'(out_data1), 32'(DEF));
    chk("pe1_occ", 32'(occ1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
